// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: word width, reset PC, BTB counter
// encodings and the training payload handed from ID to the BTB.
package fetch_pkg;

  localparam int unsigned WORD_SIZE    = 16;
  localparam int unsigned BTB_IDX_BITS = 8;
  localparam int unsigned CTR_BITS     = 2;

  typedef logic [CTR_BITS-1:0]  ctr_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  localparam word_t RESET_PC = 16'h0000;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_ALLOC = CTR_WT;
  localparam ctr_t CTR_RESET = CTR_WNT;

  // Resolved control instruction reported by ID.
  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t target;
    logic  taken;
  } btb_upd_t;

  // Saturating 2-bit direction counter step.
  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + ctr_t'(1);
    end else begin
      if (c != CTR_SNT) r = c - ctr_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB: flop-array entries, combinational lookup port and a
// single training write port with saturating direction counters.
module btb_table
  import fetch_pkg::*;
#(
  parameter int unsigned IDX_BITS = BTB_IDX_BITS
) (
  input  logic     clk,
  input  logic     reset_n,
  input  word_t    rd_pc,
  output logic     rd_taken_c,
  output word_t    rd_target_c,
  input  btb_upd_t upd
);

  localparam int unsigned ENTRIES  = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = WORD_SIZE - IDX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  word_t               target_q [ENTRIES];
  ctr_t                ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic                rd_hit;

  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0] wr_tag;
  logic                wr_hit;
  logic                wr_alloc;
  logic                wr_target_en;

  // Lookup sees pre-update contents; writes land at the next edge.
  always_comb begin
    rd_idx      = rd_pc[IDX_BITS-1:0];
    rd_tag      = rd_pc[WORD_SIZE-1:IDX_BITS];
    rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_taken_c  = rd_hit && ctr_q[rd_idx][CTR_BITS-1];
    rd_target_c = target_q[rd_idx];
  end

  always_comb begin
    wr_idx       = upd.pc[IDX_BITS-1:0];
    wr_tag       = upd.pc[WORD_SIZE-1:IDX_BITS];
    wr_hit       = upd.valid && valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    wr_alloc     = upd.valid && !wr_hit && upd.taken;
    wr_target_en = wr_alloc || (wr_hit && upd.taken);
  end

  // Valid bits and counters are reset; tag/target are qualified by valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_hit) begin
      ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], upd.taken);
    end else if (wr_alloc) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= CTR_ALLOC;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_alloc)     tag_q[wr_idx]    <= wr_tag;
    if (wr_target_en) target_q[wr_idx] <= upd.target;
  end

endmodule

// File: rtl/fetch_pc_btb.sv
// IF-stage PC generator: PC register with halt/flush/stall priority and a
// BTB-predicted successor that is trained by branches resolved in ID.
module fetch_pc_btb
  import fetch_pkg::*;
#(
  parameter int unsigned IDX_BITS = BTB_IDX_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 icache_ready,
  input  logic                 halt,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] correct_address,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_taken,
  output logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] next_pc,
  output logic                 pred_taken
);

  word_t    pc_q;
  word_t    pc_d;
  word_t    btb_target;
  logic     btb_taken;
  btb_upd_t upd;

  always_comb begin
    upd.valid  = upd_valid;
    upd.pc     = upd_pc;
    upd.target = upd_target;
    upd.taken  = upd_taken;
  end

  btb_table #(
    .IDX_BITS (IDX_BITS)
  ) u_btb (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_pc       (pc_q),
    .rd_taken_c  (btb_taken),
    .rd_target_c (btb_target),
    .upd         (upd)
  );

  // Sequential fallthrough wraps naturally at the word boundary.
  always_comb begin
    pred_taken = btb_taken;
    next_pc    = btb_taken ? btb_target : pc_q + word_t'(1);
  end

  // Halt beats everything; a flush redirect beats stall and I-cache miss.
  always_comb begin
    pc_d = pc_q;
    if (halt) begin
      pc_d = pc_q;
    end else if (flush) begin
      pc_d = correct_address;
    end else if (stall || !icache_ready) begin
      pc_d = pc_q;
    end else begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  assign if_pc = pc_q;

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Directed plus randomized bench for fetch_pc_btb against a behavioural
// model that tracks each BTB slot by the full PC that owns it.
module tb_fetch_pc_btb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, icache_ready, halt, flush;
  logic [15:0] correct_address;
  logic        upd_valid;
  logic [15:0] upd_pc, upd_target;
  logic        upd_taken;
  logic [15:0] if_pc, next_pc;
  logic        pred_taken;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_valid [256];
  int m_owner [256];
  int m_tgt   [256];
  int m_ctr   [256];
  int m_pc;

  int pool [8] = '{'h0005, 'h0105, 'h0010, 'h0011, 'h0012, 'h0020, 'hFFFF, 'h0205};

  always #5 clk = ~clk;

  fetch_pc_btb dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .icache_ready    (icache_ready),
    .halt            (halt),
    .flush           (flush),
    .correct_address (correct_address),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_taken       (upd_taken),
    .if_pc           (if_pc),
    .next_pc         (next_pc),
    .pred_taken      (pred_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit m_pred(input int pc);
    int i = pc % 256;
    return m_valid[i] && (m_owner[i] == pc) && (m_ctr[i] >= 2);
  endfunction

  function automatic int m_next(input int pc);
    return m_pred(pc) ? m_tgt[pc % 256] : (pc + 1) % 65536;
  endfunction

  task automatic m_reset();
    m_pc = 0;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic m_train(input int pc, input int tgt, input bit tk);
    int i = pc % 256;
    if (m_valid[i] && m_owner[i] == pc) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_owner[i] = pc;
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/if_pc"},      32'(if_pc),      32'(m_pc));
    check({tag, "/next_pc"},    32'(next_pc),    32'(m_next(m_pc)));
    check({tag, "/pred_taken"}, 32'(pred_taken), 32'(m_pred(m_pc)));
  endtask

  task automatic clear_inputs();
    stall = 0; icache_ready = 0; halt = 0; flush = 0; correct_address = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
  endtask

  // Called at a falling edge: drive, advance the model, check after the edge.
  task automatic cycle(input string tag, input bit st, input bit ic, input bit hl,
                       input bit fl, input int ca, input bit uv, input int up,
                       input int ut, input bit tk);
    int npc;
    stall = st; icache_ready = ic; halt = hl; flush = fl;
    correct_address = 16'(ca);
    upd_valid = uv; upd_pc = 16'(up); upd_target = 16'(ut); upd_taken = tk;
    if (hl)            npc = m_pc;
    else if (fl)       npc = ca;
    else if (st || !ic) npc = m_pc;
    else               npc = m_next(m_pc);
    if (uv) m_train(up, ut, tk);
    m_pc = npc;
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Asynchronous reset asserted between edges; checked before any clock edge.
  task automatic do_reset(input string tag);
    clear_inputs();
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check({tag, "/if_pc_now"}, 32'(if_pc), 32'h0);
    check({tag, "/next_pc_now"}, 32'(next_pc), 32'h1);
    check_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit halted;
    clear_inputs();
    reset_n = 1'b0;
    m_reset();
    @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;

    cycle("inc1", 0, 1, 0, 0, 0, 0, 0, 0, 0); check("inc1_pc", 32'(if_pc), 32'h1);
    cycle("inc2", 0, 1, 0, 0, 0, 0, 0, 0, 0); check("inc2_pc", 32'(if_pc), 32'h2);
    cycle("inc3", 0, 1, 0, 0, 0, 0, 0, 0, 0); check("inc3_pc", 32'(if_pc), 32'h3);
    cycle("fl_ffff", 0, 1, 0, 1, 'hFFFF, 0, 0, 0, 0); check("fl_ffff_pc", 32'(if_pc), 32'hFFFF);
    cycle("wrap", 0, 1, 0, 0, 0, 0, 0, 0, 0); check("wrap_pc", 32'(if_pc), 32'h0);

    cycle("train5", 0, 1, 0, 0, 0, 1, 'h5, 'h20, 1);
    cycle("to5", 0, 1, 0, 1, 'h5, 0, 0, 0, 0);
    check("to5_pred", 32'(pred_taken), 32'h1);
    check("to5_next", 32'(next_pc), 32'h20);
    cycle("take5", 0, 1, 0, 0, 0, 0, 0, 0, 0); check("take5_pc", 32'(if_pc), 32'h20);

    cycle("to5b", 0, 1, 0, 1, 'h5, 0, 0, 0, 0);
    cycle("nt1", 0, 0, 0, 0, 0, 1, 'h5, 'h20, 0); check("nt1_next", 32'(next_pc), 32'h6);
    cycle("nt2", 0, 0, 0, 0, 0, 1, 'h5, 'h20, 0); check("nt2_next", 32'(next_pc), 32'h6);
    cycle("t1", 0, 0, 0, 0, 0, 1, 'h5, 'h20, 1);  check("t1_pred", 32'(pred_taken), 32'h0);
    cycle("t2", 0, 0, 0, 0, 0, 1, 'h5, 'h20, 1);  check("t2_next", 32'(next_pc), 32'h20);

    cycle("alias", 0, 0, 0, 0, 0, 1, 'h105, 'h200, 1); check("alias_next5", 32'(next_pc), 32'h6);
    cycle("to105", 0, 1, 0, 1, 'h105, 0, 0, 0, 0);     check("to105_next", 32'(next_pc), 32'h200);
    cycle("to20", 0, 1, 0, 1, 'h20, 0, 0, 0, 0);       check("to20_pc", 32'(if_pc), 32'h20);

    do_reset("areset");
    cycle("post5", 0, 1, 0, 1, 'h5, 0, 0, 0, 0);     check("post5_pred", 32'(pred_taken), 32'h0);
    cycle("post105", 0, 1, 0, 1, 'h105, 0, 0, 0, 0); check("post105_next", 32'(next_pc), 32'h106);

    cycle("fl_ovr", 1, 0, 0, 1, 'h40, 0, 0, 0, 0);    check("fl_ovr_pc", 32'(if_pc), 32'h40);
    cycle("fl_halt", 0, 1, 1, 1, 'h80, 0, 0, 0, 0);   check("fl_halt_pc", 32'(if_pc), 32'h40);
    cycle("halt_hold", 0, 1, 1, 0, 0, 0, 0, 0, 0);    check("halt_hold_pc", 32'(if_pc), 32'h40);
    do_reset("rst2");

    halted = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit st, ic, fl, uv, tk;
      int ca, up, ut;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset("rnd_rst");
        halted = 1'b0;
      end else begin
        if (r == 1) halted = 1'b1;
        st = ($urandom_range(0, 5) == 0);
        ic = ($urandom_range(0, 4) != 0);
        fl = ($urandom_range(0, 9) == 0);
        ca = pool[$urandom_range(0, 7)];
        uv = !st && ($urandom_range(0, 2) == 0);
        up = ($urandom_range(0, 1) == 0) ? m_pc : pool[$urandom_range(0, 7)];
        ut = pool[$urandom_range(0, 7)];
        tk = ($urandom_range(0, 2) != 0);
        cycle("rnd", st, ic, halted, fl, ca, uv, up, ut, tk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
